mem_map_fp: RTL and testbench

- Go/done-controlled engine that streams `len` signed two's-complement elements from a source 1-D memory to a destination 1-D memory.
- Applies a run-time-selected saturating unary op to each element on the way through.
- Generalises the single-element identity copy: adds width/depth parameters, a length, an op select and a sticky saturation flag.
- Sits as a leaf component under a control FSM; drives std_mem_d1-style ports (combinational read, registered write done).

---
 rtl/mem_map_fp.sv | 128 ++++++++++++
 tb/tb_mem_map_fp.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_map_fp.sv
// Purpose: streams len signed elements src->dst through a saturating unary op (identity/negate/abs/shl1).
// Latency: 3 cycles per element with a one-cycle write ack; go at cycle 0 -> done at 3*min(len,SIZE)+1.
// Backpressure: holds in WAIT until dst_done; go is ignored while a run is in flight.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   go, len, op           start request, element count, op select (len/op sampled at run start)
//   done, sat             one-cycle completion pulse, sticky "some element saturated" flag
//   src_addr0/read_data   source memory, combinational read
//   dst_addr0/write_data/write_en/done   destination memory, acknowledged write
module mem_map_fp #(
  parameter int WIDTH    = 4,
  parameter int SIZE     = 16,
  parameter int IDX_SIZE = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                go,
  input  logic [IDX_SIZE:0]   len,
  input  logic [1:0]          op,
  output logic                done,
  output logic                sat,
  output logic [IDX_SIZE-1:0] src_addr0,
  input  logic [WIDTH-1:0]    src_read_data,
  output logic [IDX_SIZE-1:0] dst_addr0,
  output logic [WIDTH-1:0]    dst_write_data,
  output logic                dst_write_en,
  input  logic                dst_done
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_WAIT, S_DONE} state_t;

  localparam logic [IDX_SIZE:0]      SIZE_L = (IDX_SIZE+1)'(SIZE);
  localparam logic [IDX_SIZE:0]      ONE    = (IDX_SIZE+1)'(1);
  // Saturation bounds expressed one bit wider than the element.
  localparam logic signed [WIDTH:0]  MAX_E  = {2'b00, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH:0]  MIN_E  = {2'b11, {(WIDTH-1){1'b0}}};

  state_t state, state_nxt;

  logic [IDX_SIZE:0] index, index_inc, len_r, len_c;
  logic [1:0]        op_r;
  logic [WIDTH-1:0]  data_r;

  logic signed [WIDTH:0] x_e, raw;
  logic                  f_sat;
  logic [WIDTH-1:0]      f_val;

  assign index_inc      = index + ONE;
  assign len_c          = (len > SIZE_L) ? SIZE_L : len;
  assign dst_write_data = data_r;

  // Element op evaluated in WIDTH+1 bits so -MIN and 2x never wrap before clamping.
  always_comb begin
    x_e = {src_read_data[WIDTH-1], src_read_data};
    raw = x_e;
    case (op_r)
      2'd0:    raw = x_e;
      2'd1:    raw = -x_e;
      2'd2:    raw = x_e[WIDTH] ? -x_e : x_e;
      default: raw = x_e <<< 1;
    endcase
    f_sat = (raw > MAX_E) || (raw < MIN_E);
    if (raw > MAX_E)      f_val = MAX_E[WIDTH-1:0];
    else if (raw < MIN_E) f_val = MIN_E[WIDTH-1:0];
    else                  f_val = raw[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    done         = 1'b0;
    dst_write_en = 1'b0;
    case (state)
      S_IDLE:  if (go) state_nxt = (len_c != '0) ? S_READ : S_DONE;
      S_READ:  state_nxt = S_WRITE;
      S_WRITE: begin
        dst_write_en = 1'b1;
        state_nxt    = S_WAIT;
      end
      // An ack seen during WRITE is deliberately not looked at; only WAIT samples it.
      S_WAIT:  if (dst_done) state_nxt = (index_inc == len_r) ? S_DONE : S_READ;
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      index     <= '0;
      len_r     <= '0;
      op_r      <= '0;
      data_r    <= '0;
      sat       <= 1'b0;
      src_addr0 <= '0;
      dst_addr0 <= '0;
    end else begin
      case (state)
        S_IDLE: if (go) begin
          len_r     <= len_c;
          op_r      <= op;
          sat       <= 1'b0;
          index     <= '0;
          src_addr0 <= '0;
        end
        S_READ: begin
          data_r    <= f_val;
          dst_addr0 <= index[IDX_SIZE-1:0];
          if (f_sat) sat <= 1'b1;
        end
        // src_addr0 is advanced here so it already points at the next element in READ.
        S_WAIT: if (dst_done) begin
          index     <= index_inc;
          src_addr0 <= index_inc[IDX_SIZE-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_map_fp.sv
module tb_mem_map_fp;
  localparam int W    = 4;
  localparam int SZ   = 16;
  localparam int IW   = 4;
  localparam int MAXV = (1 << (W-1)) - 1;
  localparam int MINV = -(1 << (W-1));

  logic          clk = 1'b0;
  logic          reset, go;
  logic [IW:0]   len;
  logic [1:0]    op;
  logic          done, sat;
  logic [IW-1:0] src_addr0, dst_addr0;
  logic [W-1:0]  src_read_data, dst_write_data;
  logic          dst_write_en, dst_done;

  always #5 clk = ~clk;

  mem_map_fp #(.WIDTH(W), .SIZE(SZ), .IDX_SIZE(IW)) dut (
    .clk(clk), .reset(reset), .go(go), .len(len), .op(op), .done(done), .sat(sat),
    .src_addr0(src_addr0), .src_read_data(src_read_data), .dst_addr0(dst_addr0),
    .dst_write_data(dst_write_data), .dst_write_en(dst_write_en), .dst_done(dst_done)
  );

  // Source memory (combinational read) and its integer mirror for the model.
  logic [W-1:0] src_mem [SZ];
  int           src_val [SZ];
  assign src_read_data = src_mem[src_addr0];

  // Destination side: write log and ack responder (optional stall on one address).
  logic [IW+W-1:0] wr_q [$];
  int stall_addr  = -1;
  int stall_delay = 1;
  int cnt;
  always @(posedge clk) if (dst_write_en) wr_q.push_back({dst_addr0, dst_write_data});
  always @(posedge clk or negedge reset) begin
    if (!reset)            cnt <= 0;
    else if (dst_write_en) cnt <= (int'(dst_addr0) == stall_addr) ? stall_delay : 1;
    else if (cnt != 0)     cnt <= cnt - 1;
  end
  assign dst_done = (cnt == 1);

  // Address/data must stay put from the write strobe until the ack.
  logic          in_wait = 1'b0;
  logic [IW-1:0] cap_a;
  logic [W-1:0]  cap_d;
  int            stab_err = 0;
  always @(negedge clk) begin
    if (!reset) in_wait <= 1'b0;
    else if (dst_write_en) begin
      in_wait <= 1'b1; cap_a <= dst_addr0; cap_d <= dst_write_data;
    end else if (in_wait) begin
      if (dst_addr0 != cap_a || dst_write_data != cap_d) stab_err <= stab_err + 1;
      if (dst_done) in_wait <= 1'b0;
    end
  end

  int n_pass = 0, n_total = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic int wdat(input int k);
    logic [W-1:0] d;
    d = wr_q[k][W-1:0];
    return int'($signed(d));
  endfunction

  function automatic int wadr(input int k);
    return int'(wr_q[k][W +: IW]);
  endfunction

  // Specification-level model of one element.
  function automatic void ref_f(input int o, input int x, output int r, output int s);
    int raw;
    case (o)
      0:       raw = x;
      1:       raw = -x;
      2:       raw = (x < 0) ? -x : x;
      default: raw = 2 * x;
    endcase
    r = (raw > MAXV) ? MAXV : ((raw < MINV) ? MINV : raw);
    s = (r != raw) ? 1 : 0;
  endfunction

  task automatic set_src(input int i, input int x);
    logic [31:0] t;
    t          = x;
    src_val[i] = x;
    src_mem[i] = t[W-1:0];
  endtask

  task automatic rand_src();
    for (int i = 0; i < SZ; i++) set_src(i, int'($urandom_range(0, (1 << W) - 1)) + MINV);
  endtask

  // Starts a run in an IDLE cycle (cycle 0), returns the cycle done is seen, ends in IDLE.
  task automatic run(input int n, input int o, output int dcyc);
    int cyc;
    dcyc = -1;
    @(negedge clk);
    go = 1'b1; len = (IW+1)'(n); op = 2'(o);
    cyc = 0;
    while (cyc < 400) begin
      @(posedge clk); #1; cyc++;
      if (done) begin dcyc = cyc; break; end
      if (cyc == 2) begin len = (IW+1)'($urandom); op = 2'($urandom); end
    end
    go = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_run(input string nm, input int n, input int o, input int exp_dcyc,
                        output int base);
    int dc, lr, s, r, es, nw;
    base = wr_q.size();
    lr   = (n > SZ) ? SZ : n;
    s    = 0;
    run(n, o, dc);
    nw = wr_q.size() - base;
    check({nm, " done_cycle"}, dc, exp_dcyc);
    check({nm, " writes"}, nw, lr);
    for (int i = 0; i < lr && i < nw; i++) begin
      ref_f(o, src_val[i], r, es);
      s |= es;
      check($sformatf("%s addr[%0d]", nm, i), wadr(base + i), i);
      check($sformatf("%s data[%0d]", nm, i), wdat(base + i), r);
    end
    check({nm, " sat"}, int'(sat), s);
  endtask

  typedef struct {
    int len; int op; int src[4]; int exp[4]; int sat; int dcyc;
  } vec_t;
  vec_t vecs[5];

  initial begin
    int base, cyc, d1, d2, nw;

    vecs[0].len = 4; vecs[0].op = 0; vecs[0].src = '{3, -8, 7, -1}; vecs[0].exp = '{3, -8, 7, -1};
    vecs[0].sat = 0; vecs[0].dcyc = 13;
    vecs[1].len = 3; vecs[1].op = 1; vecs[1].src = '{-8, 5, 0, 0};  vecs[1].exp = '{7, -5, 0, 0};
    vecs[1].sat = 1; vecs[1].dcyc = 10;
    vecs[2].len = 3; vecs[2].op = 2; vecs[2].src = '{-8, 5, 0, 0};  vecs[2].exp = '{7, 5, 0, 0};
    vecs[2].sat = 1; vecs[2].dcyc = 10;
    vecs[3].len = 4; vecs[3].op = 3; vecs[3].src = '{3, 4, -4, -5}; vecs[3].exp = '{6, 7, -8, -8};
    vecs[3].sat = 1; vecs[3].dcyc = 13;
    vecs[4].len = 2; vecs[4].op = 3; vecs[4].src = '{1, -2, 0, 0};  vecs[4].exp = '{2, -4, 0, 0};
    vecs[4].sat = 0; vecs[4].dcyc = 7;

    reset = 1'b0; go = 1'b0; len = '0; op = '0;
    rand_src();
    repeat (2) @(posedge clk); #1;
    check("rst done", int'(done), 0);
    check("rst sat", int'(sat), 0);
    check("rst we", int'(dst_write_en), 0);
    check("rst src_addr", int'(src_addr0), 0);
    check("rst dst_addr", int'(dst_addr0), 0);
    check("rst wdata", int'(dst_write_data), 0);
    @(negedge clk); reset = 1'b1;

    // Table-driven directed vectors.
    foreach (vecs[v]) begin
      for (int j = 0; j < 4; j++) set_src(j, vecs[v].src[j]);
      do_run($sformatf("vec%0d", v), vecs[v].len, vecs[v].op, vecs[v].dcyc, base);
      for (int j = 0; j < vecs[v].len && base + j < wr_q.size(); j++)
        check($sformatf("vec%0d table[%0d]", v, j), wdat(base + j), vecs[v].exp[j]);
      check($sformatf("vec%0d table sat", v), int'(sat), vecs[v].sat);
    end

    // Length boundaries.
    do_run("len0", 0, 0, 1, base);
    rand_src();
    do_run("len20", 20, 1, 49, base);

    // go held across done: second run starts in the IDLE cycle after DONE.
    @(negedge clk);
    base = wr_q.size();
    go = 1'b1; len = 2; op = 0;
    cyc = 0; d1 = -1; d2 = -1;
    while (cyc < 100 && d2 < 0) begin
      @(posedge clk); #1; cyc++;
      if (done) begin
        if (d1 < 0) d1 = cyc; else d2 = cyc;
      end
    end
    go = 1'b0;
    @(posedge clk); #1;
    check("gohold first done", d1, 7);
    check("gohold second done", d2, 15);
    check("gohold writes", wr_q.size() - base, 4);

    // Write-ack stall on element 1.
    rand_src();
    stall_addr = 1; stall_delay = 5;
    do_run("stall", 3, 0, 14, base);
    stall_addr = -1; stall_delay = 1;

    // Asynchronous reset while waiting on element 2's ack.
    set_src(0, -8); set_src(1, 3); set_src(2, 5); set_src(3, -2);
    stall_addr = 2; stall_delay = 8;
    base = wr_q.size();
    @(negedge clk);
    go = 1'b1; len = 4; op = 1;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (wr_q.size() - base >= 3) break;
    end
    go = 1'b0;
    check("prerst writes", wr_q.size() - base, 3);
    check("prerst sat", int'(sat), 1);
    check("prerst wdata", int'($signed(dst_write_data)), -5);
    #2 reset = 1'b0;
    #1;
    check("midrst done", int'(done), 0);
    check("midrst sat", int'(sat), 0);
    check("midrst we", int'(dst_write_en), 0);
    check("midrst src_addr", int'(src_addr0), 0);
    check("midrst dst_addr", int'(dst_addr0), 0);
    check("midrst wdata", int'(dst_write_data), 0);
    repeat (5) @(posedge clk);
    #1;
    check("midrst no writes", wr_q.size() - base, 3);
    @(negedge clk);
    reset = 1'b1;
    stall_addr = -1; stall_delay = 1;
    do_run("rst_rerun", 4, 1, 13, base);

    // Randomized runs against the model.
    for (int k = 0; k < 8; k++) begin
      int n, o, lr;
      rand_src();
      n  = int'($urandom_range(0, 2 * SZ - 1));
      o  = int'($urandom_range(0, 3));
      lr = (n > SZ) ? SZ : n;
      if (k == 3) begin stall_addr = int'($urandom_range(0, SZ - 1)); stall_delay = 4; end
      else        begin stall_addr = -1; stall_delay = 1; end
      nw = (stall_addr >= 0 && stall_addr < lr) ? 3 : 0;
      do_run($sformatf("rand%0d", k), n, o, (lr == 0) ? 1 : 3 * lr + 1 + nw, base);
    end

    check("wait stability errors", stab_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
